// File: rtl/shift_rows_stream_pkg.sv
// Shared constants and helpers for the column-serial (Inv)ShiftRows stage.
// Also provides the per-row shift offsets for Nb = 4, 6 and 8.
package shift_rows_stream_pkg;

  localparam int AES_COL_W = 32;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } sr_mode_e;

  // Byte lane of a state column; row 0 sits in the most significant byte.
  function automatic logic [7:0] col_byte(input logic [AES_COL_W-1:0] col, input int row);
    return col[(AES_COL_W-1)-8*row -: 8];
  endfunction

  function automatic int shift_offset(input int nb, input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/shift_rows_stream_if.sv
// Valid/ready column stream; the master side also carries block framing and mode.
interface shift_rows_stream_if;
  import shift_rows_stream_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [AES_COL_W-1:0] data;
  logic                 inv;
  logic                 last;

  modport master (output valid, output data, output inv, output last, input ready);
  modport slave  (input valid, input data, input inv, output ready);

endinterface

// File: rtl/shift_rows_stream_perm.sv
// Combinational (Inv)ShiftRows selection of one output column from a full block.
module shift_rows_stream_perm
  import shift_rows_stream_pkg::*;
#(
  parameter int NB = 4,
  parameter int CW = $clog2(NB)
) (
  input  logic [NB-1:0][AES_COL_W-1:0] i_cols,
  input  logic [CW-1:0]                i_col,
  input  logic                         i_inv,
  output logic [AES_COL_W-1:0]         o_col
);

  localparam logic [CW:0] NBW = (CW+1)'(NB);

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam logic [CW:0] OFF = (CW+1)'(shift_offset(NB, r));

    logic [CW:0]   w_col_x;
    logic [CW:0]   w_fwd_raw;
    logic [CW:0]   w_fwd;
    logic [CW:0]   w_inv;
    logic [CW-1:0] w_src;

    // One extra bit of headroom so the wrap at NB works for non-power-of-two NB.
    assign w_col_x   = {1'b0, i_col};
    assign w_fwd_raw = w_col_x + OFF;
    assign w_fwd     = (w_fwd_raw >= NBW) ? (w_fwd_raw - NBW) : w_fwd_raw;
    assign w_inv     = (w_col_x >= OFF) ? (w_col_x - OFF) : (w_col_x + NBW - OFF);
    assign w_src     = i_inv ? w_inv[CW-1:0] : w_fwd[CW-1:0];

    assign o_col[(AES_COL_W-1)-8*r -: 8] = col_byte(i_cols[w_src], r);
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming (Inv)ShiftRows: ping-pong buffers one NB-column block while the
// other bank is read out permuted, sustaining one column per cycle.
module shift_rows_stream
  import shift_rows_stream_pkg::*;
#(
  parameter int NB         = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = $clog2(NB)
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_rows_stream_if.slave  s,
  shift_rows_stream_if.master m
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end
  if (DATA_WIDTH != AES_COL_W) begin : g_bad_width
    $error("shift_rows_stream: DATA_WIDTH must be 32");
  end

  logic [1:0][NB-1:0][AES_COL_W-1:0] r_bank;
  sr_mode_e                          r_mode [2];
  logic [1:0]                        r_full;
  logic                              r_wsel;
  logic                              r_rsel;
  logic [CW-1:0]                     r_wcnt;
  logic [CW-1:0]                     r_rcnt;

  logic                 w_s_ready;
  logic                 w_s_acc;
  logic                 w_m_valid;
  logic                 w_m_acc;
  logic                 w_wlast;
  logic                 w_rlast;
  logic                 w_rd_inv;
  logic [AES_COL_W-1:0] w_perm_col;

  assign w_s_ready = ~r_full[r_wsel];
  assign w_s_acc   = s.valid & w_s_ready;
  assign w_m_valid = r_full[r_rsel];
  assign w_m_acc   = w_m_valid & m.ready;
  assign w_wlast   = (r_wcnt == CW'(NB-1));
  assign w_rlast   = (r_rcnt == CW'(NB-1));
  assign w_rd_inv  = (r_mode[r_rsel] == MODE_INV);

  assign s.ready = w_s_ready;
  assign m.valid = w_m_valid;

  // Column storage needs no reset: a bank is only read once its full flag is set.
  always_ff @(posedge clk) begin
    if (w_s_acc) begin
      r_bank[r_wsel][r_wcnt] <= s.data;
    end
  end

  // Bank flags, selects, counters and per-bank mode; writer and reader never touch the same flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wsel    <= 1'b0;
      r_rsel    <= 1'b0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_mode[0] <= MODE_FWD;
      r_mode[1] <= MODE_FWD;
    end else begin
      if (w_s_acc) begin
        if (r_wcnt == '0) begin
          r_mode[r_wsel] <= sr_mode_e'(s.inv);
        end
        if (w_wlast) begin
          r_full[r_wsel] <= 1'b1;
          r_wsel         <= ~r_wsel;
          r_wcnt         <= '0;
        end else begin
          r_wcnt <= r_wcnt + CW'(1);
        end
      end
      if (w_m_acc) begin
        if (w_rlast) begin
          r_full[r_rsel] <= 1'b0;
          r_rsel         <= ~r_rsel;
          r_rcnt         <= '0;
        end else begin
          r_rcnt <= r_rcnt + CW'(1);
        end
      end
    end
  end

  shift_rows_stream_perm #(.NB(NB), .CW(CW)) u_perm (
    .i_cols (r_bank[r_rsel]),
    .i_col  (r_rcnt),
    .i_inv  (w_rd_inv),
    .o_col  (w_perm_col)
  );

  // Output payload is zeroed whenever no column is being offered.
  always_comb begin
    m.data = '0;
    m.last = 1'b0;
    m.inv  = 1'b0;
    if (w_m_valid) begin
      m.data = w_perm_col;
      m.last = w_rlast;
      m.inv  = w_rd_inv;
    end else begin
      m.data = '0;
      m.last = 1'b0;
      m.inv  = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream at NB=4 (main), NB=8 and NB=6.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  shift_rows_stream_if s4 ();
  shift_rows_stream_if m4 ();
  shift_rows_stream_if s8 ();
  shift_rows_stream_if m8 ();
  shift_rows_stream_if s6 ();
  shift_rows_stream_if m6 ();

  shift_rows_stream #(.NB(4)) u4 (.clk(clk), .rst_n(rst_n), .s(s4), .m(m4));
  shift_rows_stream #(.NB(8)) u8 (.clk(clk), .rst_n(rst_n), .s(s8), .m(m8));
  shift_rows_stream #(.NB(6)) u6 (.clk(clk), .rst_n(rst_n), .s(s6), .m(m6));

  typedef struct {
    logic [31:0] din;
    logic        inv;
    logic [31:0] dout;
    logic        last;
    logic        minv;
  } vec_t;

  vec_t        vec [8];
  logic [31:0] blk [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model working on whole-int indices with modulo wrap.
  function automatic logic [31:0] ref_col(input int nb, input int c, input bit inv);
    int          offs [4];
    int          src;
    logic [31:0] res;
    logic [31:0] w;
    offs[0] = 0;
    offs[1] = 1;
    offs[2] = (nb == 8) ? 3 : 2;
    offs[3] = (nb == 8) ? 4 : 3;
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      src = inv ? ((c - offs[r] + nb) % nb) : ((c + offs[r]) % nb);
      w = blk[src];
      res[31-8*r -: 8] = w[31-8*r -: 8];
    end
    return res;
  endfunction

  task automatic send4(input logic [31:0] d, input logic inv);
    int n = 0;
    @(negedge clk);
    s4.valid = 1'b1;
    s4.data  = d;
    s4.inv   = inv;
    while (!s4.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s4.ready) begin
      total++;
      bad++;
      $display("FAIL send4_timeout: got s_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 s4.valid = 1'b0;
  endtask

  task automatic recv4(input string nm, input logic [31:0] ed, input logic el, input logic ei);
    @(negedge clk);
    m4.ready = 1'b1;
    chk({nm, "_valid"}, 32'(m4.valid), 32'd1);
    chk({nm, "_data"}, m4.data, ed);
    chk({nm, "_last"}, 32'(m4.last), 32'(el));
    chk({nm, "_inv"}, 32'(m4.inv), 32'(ei));
    @(posedge clk);
    #1 m4.ready = 1'b0;
  endtask

  task automatic run_wide(input int nb, input bit inv, input string nm);
    logic        rdy, v, l, mi;
    logic [31:0] d;
    for (int c = 0; c < nb; c++) begin
      @(negedge clk);
      if (nb == 8) begin
        s8.valid = 1'b1; s8.data = blk[c]; s8.inv = inv; rdy = s8.ready;
      end else begin
        s6.valid = 1'b1; s6.data = blk[c]; s6.inv = inv; rdy = s6.ready;
      end
      chk({nm, "_sready"}, 32'(rdy), 32'd1);
      @(posedge clk);
    end
    #1;
    s8.valid = 1'b0;
    s6.valid = 1'b0;
    for (int c = 0; c < nb; c++) begin
      @(negedge clk);
      if (nb == 8) begin
        m8.ready = 1'b1; v = m8.valid; d = m8.data; l = m8.last; mi = m8.inv;
      end else begin
        m6.ready = 1'b1; v = m6.valid; d = m6.data; l = m6.last; mi = m6.inv;
      end
      chk({nm, "_valid"}, 32'(v), 32'd1);
      chk({nm, "_data"}, d, ref_col(nb, c, inv));
      chk({nm, "_last"}, 32'(l), 32'(c == nb - 1));
      chk({nm, "_inv"}, 32'(mi), 32'(inv));
      if (nb == 8 && c == 0) chk("nb8_col0_fixed", d, 32'h00050e13);
      @(posedge clk);
    end
    #1;
    m8.ready = 1'b0;
    m6.ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d3 [12];
    logic [31:0] e3 [12];
    logic        md3 [3];

    vec[0] = '{32'hd42711ae, 1'b0, 32'hd4bf5d30, 1'b0, 1'b0};
    vec[1] = '{32'he0bf98f1, 1'b0, 32'he0b452ae, 1'b0, 1'b0};
    vec[2] = '{32'hb8b45de5, 1'b0, 32'hb84111f1, 1'b0, 1'b0};
    vec[3] = '{32'h1e415230, 1'b0, 32'h1e2798e5, 1'b1, 1'b0};
    vec[4] = '{32'hd4bf5d30, 1'b1, 32'hd42711ae, 1'b0, 1'b1};
    vec[5] = '{32'he0b452ae, 1'b0, 32'he0bf98f1, 1'b0, 1'b1};
    vec[6] = '{32'hb84111f1, 1'b0, 32'hb8b45de5, 1'b0, 1'b1};
    vec[7] = '{32'h1e2798e5, 1'b0, 32'h1e415230, 1'b1, 1'b1};

    s4.valid = 1'b0; s4.data = '0; s4.inv = 1'b0; m4.ready = 1'b0;
    s8.valid = 1'b0; s8.data = '0; s8.inv = 1'b0; m8.ready = 1'b0;
    s6.valid = 1'b0; s6.data = '0; s6.inv = 1'b0; m6.ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m4.valid), 32'd0);
    chk("rst_s_ready", 32'(s4.ready), 32'd1);
    chk("rst_m_data", m4.data, 32'h0);
    chk("rst_m_last", 32'(m4.last), 32'd0);
    chk("rst_m_inv", 32'(m4.inv), 32'd0);

    // FIPS-197 round-1 forward block, then inverse returns the original (table-driven)
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) send4(vec[4*b+c].din, vec[4*b+c].inv);
      for (int c = 0; c < 4; c++)
        recv4($sformatf("vec%0d", 4*b+c), vec[4*b+c].dout, vec[4*b+c].last, vec[4*b+c].minv);
    end

    // Three back-to-back blocks, alternating modes, m_ready held high
    md3[0] = 1'b0; md3[1] = 1'b1; md3[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d3[k]     = vec[k].din;
      d3[4 + k] = vec[4 + k].din;
      d3[8 + k] = 32'h01234567 + 32'h11111111 * 32'(k);
    end
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) blk[k] = d3[4*b+k];
      for (int k = 0; k < 4; k++) e3[4*b+k] = ref_col(4, k, md3[b]);
    end
    m4.ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          s4.valid = 1'b1;
          s4.data  = d3[k];
          s4.inv   = (k % 4 == 0) ? md3[k/4] : ~md3[k/4];
          chk("t3_sready", 32'(s4.ready), 32'd1);
          @(posedge clk);
        end
        #1 s4.valid = 1'b0;
      end
      begin
        int n = 0;
        int first = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
          @(negedge clk);
          if (n < 12) begin
            if (m4.valid) begin
              if (first < 0) first = cyc;
              chk($sformatf("t3_data%0d", n), m4.data, e3[n]);
              chk($sformatf("t3_inv%0d", n), 32'(m4.inv), 32'(md3[n/4]));
              chk($sformatf("t3_last%0d", n), 32'(m4.last), 32'(n % 4 == 3));
              n++;
            end else if (first >= 0) begin
              chk("t3_bubble", 32'(m4.valid), 32'd1);
            end
          end
        end
        chk("t3_first_valid_cycle", 32'(first), 32'd4);
        chk("t3_count", 32'(n), 32'd12);
      end
    join
    m4.ready = 1'b0;

    // Back-pressure: two blocks fill both banks, output held while stalled
    for (int k = 0; k < 4; k++) send4(vec[k].din, 1'b0);
    for (int k = 0; k < 4; k++) send4(d3[8+k], 1'b1);
    @(negedge clk);
    chk("t4_full_sready", 32'(s4.ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", 32'(m4.valid), 32'd1);
      chk("t4_stall_data", m4.data, vec[0].dout);
      chk("t4_stall_sready", 32'(s4.ready), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      recv4($sformatf("t4a%0d", k), vec[k].dout, 1'(k == 3), 1'b0);
      chk($sformatf("t4_sready_after%0d", k), 32'(s4.ready), 32'(k == 3));
    end
    for (int k = 0; k < 4; k++) blk[k] = d3[8+k];
    for (int k = 0; k < 4; k++) recv4($sformatf("t4b%0d", k), ref_col(4, k, 1'b1), 1'(k == 3), 1'b1);

    // Reset in the middle of a block discards the partial block
    send4(32'hdeadbeef, 1'b1);
    send4(32'hcafef00d, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t5_m_valid", 32'(m4.valid), 32'd0);
    chk("t5_s_ready", 32'(s4.ready), 32'd1);
    for (int k = 0; k < 4; k++) blk[k] = 32'h0a0b0c0d + 32'h10203040 * 32'(k);
    for (int k = 0; k < 4; k++) send4(blk[k], 1'b0);
    for (int k = 0; k < 4; k++) recv4($sformatf("t5_%0d", k), ref_col(4, k, 1'b0), 1'(k == 3), 1'b0);

    // Wider states: NB=8 offsets 1,3,4 and NB=6 wrap at column 5
    for (int c = 0; c < 8; c++) blk[c] = 32'h00010203 + 32'h04040404 * 32'(c);
    run_wide(8, 1'b0, "nb8_fwd");
    for (int c = 0; c < 6; c++) blk[c] = 32'h10213243 + 32'h01050911 * 32'(c);
    run_wide(6, 1'b0, "nb6_fwd");
    run_wide(6, 1'b1, "nb6_inv");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
